// File: rtl/bit_lock_scan_ctrl.sv
// Scans N_LANES serial lanes through one shared lock detector: clear, acquire
// within a timeout window, confirm HOLD samples, then monitor for loss of lock.
module bit_lock_scan_ctrl #(
  parameter int unsigned N_LANES  = 4,
  parameter int unsigned TIMEOUT  = 32,
  parameter int unsigned HOLD     = 8,
  parameter int unsigned LOL_FILT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [N_LANES-1:0]         lane_mask,
  input  logic                       det_lock,
  output logic                       det_en,
  output logic                       det_clr,
  output logic [$clog2(N_LANES)-1:0] lane_sel,
  output logic                       busy,
  output logic                       locked,
  output logic                       fail,
  output logic                       lol
);
  localparam int unsigned LW = $clog2(N_LANES);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned HW = $clog2(HOLD + 1);
  localparam int unsigned FW = $clog2(LOL_FILT + 1);
  localparam int unsigned CW = $clog2(N_LANES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACQ, S_CONFIRM, S_LOCKED, S_NEXT
  } state_t;

  state_t             state, state_nx;
  logic [N_LANES-1:0] mask_q, mask_nx;
  logic [TW-1:0]      tmr, tmr_nx, tmr_inc;
  logic [HW-1:0]      hold_cnt, hold_nx;
  logic [FW-1:0]      lol_cnt, lol_nx;
  logic [CW-1:0]      tried, tried_nx;
  logic [LW-1:0]      lane_nx;
  logic               fail_nx, lol_p_nx, win_end;

  logic [LW-1:0] first_lane, low_lane, above_lane, next_lane;
  logic          first_found, low_found, above_found;
  logic [CW-1:0] pop_q;

  always_comb begin
    first_lane  = '0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (lane_mask[i] && !first_found) begin
        first_lane  = LW'(i);
        first_found = 1'b1;
      end
    end
  end

  // Next lane: lowest set bit above the current one, else wrap to the lowest.
  always_comb begin
    low_lane    = '0;
    low_found   = 1'b0;
    above_lane  = '0;
    above_found = 1'b0;
    pop_q       = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      pop_q = pop_q + CW'(mask_q[i]);
      if (mask_q[i] && !low_found) begin
        low_lane  = LW'(i);
        low_found = 1'b1;
      end
      if (mask_q[i] && !above_found && (i > 32'(lane_sel))) begin
        above_lane  = LW'(i);
        above_found = 1'b1;
      end
    end
    next_lane = above_found ? above_lane : low_lane;
  end

  always_comb begin
    state_nx = state;
    mask_nx  = mask_q;
    tmr_nx   = tmr;
    hold_nx  = hold_cnt;
    lol_nx   = lol_cnt;
    tried_nx = tried;
    lane_nx  = lane_sel;
    fail_nx  = 1'b0;
    lol_p_nx = 1'b0;
    tmr_inc  = (tmr == TW'(TIMEOUT)) ? tmr : tmr + TW'(1);
    win_end  = (tmr_inc == TW'(TIMEOUT));

    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (|lane_mask) begin
            mask_nx  = lane_mask;
            lane_nx  = first_lane;
            tried_nx = CW'(1);
            state_nx = S_CLEAR;
          end else begin
            fail_nx = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        tmr_nx   = '0;
        hold_nx  = '0;
        lol_nx   = '0;
        state_nx = S_ACQ;
      end
      S_ACQ: begin
        tmr_nx = tmr_inc;
        // A first high sample on the last window cycle cannot complete HOLD
        // samples inside the window, so the window still expires.
        if (det_lock && (HOLD == 1)) begin
          state_nx = S_LOCKED;
        end else if (win_end) begin
          state_nx = S_NEXT;
        end else if (det_lock) begin
          hold_nx  = HW'(1);
          state_nx = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        tmr_nx = tmr_inc;
        if (det_lock) begin
          hold_nx = hold_cnt + HW'(1);
          if (hold_cnt + HW'(1) == HW'(HOLD)) state_nx = S_LOCKED;
          else if (win_end)                   state_nx = S_NEXT;
        end else begin
          hold_nx  = '0;
          state_nx = win_end ? S_NEXT : S_ACQ;
        end
      end
      S_LOCKED: begin
        if (det_lock) begin
          lol_nx = '0;
        end else if (lol_cnt + FW'(1) == FW'(LOL_FILT)) begin
          lol_nx   = '0;
          lol_p_nx = 1'b1;
          tried_nx = CW'(1);
          state_nx = S_CLEAR;
        end else begin
          lol_nx = lol_cnt + FW'(1);
        end
      end
      S_NEXT: begin
        if (tried == pop_q) begin
          fail_nx  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          lane_nx  = next_lane;
          tried_nx = tried + CW'(1);
          state_nx = S_CLEAR;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (abort) begin
      state_nx = S_IDLE;
      mask_nx  = mask_q;
      lane_nx  = lane_sel;
      fail_nx  = 1'b0;
      lol_p_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mask_q   <= '0;
      tmr      <= '0;
      hold_cnt <= '0;
      lol_cnt  <= '0;
      tried    <= '0;
      lane_sel <= '0;
      det_en   <= 1'b0;
      det_clr  <= 1'b0;
      busy     <= 1'b0;
      locked   <= 1'b0;
      fail     <= 1'b0;
      lol      <= 1'b0;
    end else begin
      state    <= state_nx;
      mask_q   <= mask_nx;
      tmr      <= tmr_nx;
      hold_cnt <= hold_nx;
      lol_cnt  <= lol_nx;
      tried    <= tried_nx;
      lane_sel <= lane_nx;
      det_en   <= (state_nx == S_ACQ) || (state_nx == S_CONFIRM) || (state_nx == S_LOCKED);
      det_clr  <= (state_nx == S_CLEAR);
      busy     <= (state_nx != S_IDLE);
      locked   <= (state_nx == S_LOCKED);
      fail     <= fail_nx;
      lol      <= lol_p_nx;
    end
  end

endmodule

// File: tb/tb_bit_lock_scan_ctrl.sv
// Bench for bit_lock_scan_ctrl: per-cycle traces against a procedural scan
// model, plus directed abort / reset / empty-mask scenarios.
module tb_bit_lock_scan_ctrl;
  localparam int N_LANES  = 4;
  localparam int TIMEOUT  = 32;
  localparam int HOLD     = 8;
  localparam int LOL_FILT = 4;
  localparam int NC       = 400;

  logic       clk, rst_n, start, abort, det_lock;
  logic [3:0] lane_mask;
  logic       det_en, det_clr, busy, locked, fail, lol;
  logic [1:0] lane_sel;

  int checks = 0;
  int fails  = 0;

  logic       raw     [NC];
  logic       drv     [NC];
  logic [7:0] exp_vec [NC];
  logic [7:0] act_vec [NC];
  logic [3:0] lane_ok;

  bit_lock_scan_ctrl #(
    .N_LANES (N_LANES),
    .TIMEOUT (TIMEOUT),
    .HOLD    (HOLD),
    .LOL_FILT(LOL_FILT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .lane_mask(lane_mask),
    .det_lock (det_lock),
    .det_en   (det_en),
    .det_clr  (det_clr),
    .lane_sel (lane_sel),
    .busy     (busy),
    .locked   (locked),
    .fail     (fail),
    .lol      (lol)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  // Trace word: {busy, det_en, det_clr, locked, fail, lol, lane_sel}
  function automatic logic [7:0] mk(input bit b, input bit e, input bit cl, input bit lk,
                                    input bit f, input bit lo, input int ln);
    return {b, e, cl, lk, f, lo, 2'(ln)};
  endfunction

  function automatic logic [7:0] snap();
    return {busy, det_en, det_clr, locked, fail, lol, lane_sel};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; det_lock = 1'b0; lane_mask = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Walks the scan as a sequence of lane attempts: CLEAR, a TIMEOUT-cycle
  // window looking for HOLD consecutive highs, LOCKED until LOL_FILT
  // consecutive lows, or NEXT; fail after every masked lane missed in a row.
  task automatic build_model(input logic [3:0] mask);
    int order[$];
    int m, idx, att, c, run, lows, ln;
    bit got, lol_pend, ended;
    order = {};
    for (int i = 0; i < N_LANES; i++) if (mask[i]) order.push_back(i);
    for (int k = 0; k < NC; k++) begin
      exp_vec[k] = '0;
      drv[k]     = raw[k];
    end
    m = order.size();
    if (m == 0) begin
      exp_vec[1] = mk(0, 0, 0, 0, 1, 0, 0);
      return;
    end
    idx = 0; att = 0; c = 1; ln = order[0]; lol_pend = 0; ended = 0;
    while (c < NC && !ended) begin
      exp_vec[c] = mk(1, 0, 1, 0, 0, lol_pend, ln);
      lol_pend = 0;
      c++;
      run = 0; got = 0;
      for (int w = 0; w < TIMEOUT && c < NC && !got; w++) begin
        drv[c]     = raw[c] & lane_ok[ln];
        exp_vec[c] = mk(1, 1, 0, 0, 0, 0, ln);
        run = drv[c] ? run + 1 : 0;
        c++;
        if (run == HOLD) got = 1;
      end
      if (c >= NC) break;
      if (got) begin
        lows = 0;
        while (c < NC && lows < LOL_FILT) begin
          drv[c]     = raw[c] & lane_ok[ln];
          exp_vec[c] = mk(1, 1, 0, 1, 0, 0, ln);
          lows = drv[c] ? 0 : lows + 1;
          c++;
        end
        lol_pend = 1;
        att = 0;
      end else begin
        exp_vec[c] = mk(1, 0, 0, 0, 0, 0, ln);
        c++;
        att++;
        if (att == m) begin
          for (int k = c; k < NC; k++) exp_vec[k] = mk(0, 0, 0, 0, (k == c), 0, ln);
          ended = 1;
        end else begin
          idx = (idx + 1) % m;
          ln  = order[idx];
        end
      end
    end
  endtask

  // Start at cycle 0, then drive det_lock per cycle; start and lane_mask are
  // scrambled while the scan is busy, where they must have no effect.
  task automatic run_scan(input logic [3:0] mask);
    lane_mask = mask; start = 1'b1; det_lock = 1'b0; abort = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c < NC; c++) begin
      act_vec[c] = snap();
      det_lock   = drv[c];
      start      = exp_vec[c][7] ? 1'($urandom % 2) : 1'b0;
      if (exp_vec[c][7]) lane_mask = 4'($urandom);
      tick();
    end
    start = 1'b0; det_lock = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; det_lock = 1'b1; lane_mask = 4'b1111;
    repeat (3) tick();
    checks++;
    if (snap() !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b", snap(), 8'h00);
    end
    apply_reset();
    checks++;
    if (snap() !== 8'h00) begin
      fails++;
      $display("FAIL reset_idle: got %b expected %b", snap(), 8'h00);
    end
  endtask

  task automatic test_single_lock();
    apply_reset();
    lane_ok = 4'b1111;
    for (int k = 0; k < NC; k++) raw[k] = 1'b1;
    build_model(4'b0010);
    run_scan(4'b0010);
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("FAIL single_lock_trace c=%0d: got %b expected %b", c, act_vec[c], exp_vec[c]);
      end
    end
    checks++;
    if (act_vec[1] !== mk(1, 0, 1, 0, 0, 0, 1)) begin
      fails++;
      $display("FAIL single_lock_clr_c1: got %b expected %b", act_vec[1], mk(1, 0, 1, 0, 0, 0, 1));
    end
    checks++;
    if (act_vec[9][4] !== 1'b0 || act_vec[10] !== mk(1, 1, 0, 1, 0, 0, 1)) begin
      fails++;
      $display("FAIL single_lock_c10: got c9=%b c10=%b expected locked only from c10 %b",
               act_vec[9], act_vec[10], mk(1, 1, 0, 1, 0, 0, 1));
    end
  endtask

  task automatic test_full_scan_fail();
    apply_reset();
    lane_ok = 4'b1111;
    for (int k = 0; k < NC; k++) raw[k] = 1'b0;
    build_model(4'b1111);
    run_scan(4'b1111);
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("FAIL full_scan_trace c=%0d: got %b expected %b", c, act_vec[c], exp_vec[c]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_vec[1 + k * (TIMEOUT + 2)] !== mk(1, 0, 1, 0, 0, 0, k)) begin
        fails++;
        $display("FAIL full_scan_clear_lane%0d: got %b expected %b", k,
                 act_vec[1 + k * (TIMEOUT + 2)], mk(1, 0, 1, 0, 0, 0, k));
      end
    end
    checks++;
    if ({act_vec[136][3], act_vec[137][3], act_vec[138][3], act_vec[138][7]} !== 4'b0100) begin
      fails++;
      $display("FAIL full_scan_fail_pulse: got fail136/137/138,busy138=%b expected 0100",
               {act_vec[136][3], act_vec[137][3], act_vec[138][3], act_vec[138][7]});
    end
  endtask

  task automatic test_skip_lane();
    apply_reset();
    lane_ok = 4'b1000;
    for (int k = 0; k < NC; k++) raw[k] = 1'b1;
    build_model(4'b1010);
    run_scan(4'b1010);
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("FAIL skip_lane_trace c=%0d: got %b expected %b", c, act_vec[c], exp_vec[c]);
      end
    end
    checks++;
    if (act_vec[2][1:0] !== 2'd1 || act_vec[43][4] !== 1'b0 || act_vec[44] !== mk(1, 1, 0, 1, 0, 0, 3)) begin
      fails++;
      $display("FAIL skip_lane_lock44: got c2=%b c43=%b c44=%b expected lane1 then lock on lane3 at 44",
               act_vec[2], act_vec[43], act_vec[44]);
    end
  endtask

  task automatic test_hold_restart();
    apply_reset();
    lane_ok = 4'b1111;
    for (int k = 0; k < NC; k++) raw[k] = (k >= 2 && k <= 4) || (k >= 6);
    build_model(4'b0001);
    run_scan(4'b0001);
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("FAIL hold_restart_trace c=%0d: got %b expected %b", c, act_vec[c], exp_vec[c]);
      end
    end
    checks++;
    if (act_vec[13][4] !== 1'b0 || act_vec[14][4] !== 1'b1) begin
      fails++;
      $display("FAIL hold_restart_lock14: got locked13=%b locked14=%b expected 0 1",
               act_vec[13][4], act_vec[14][4]);
    end

    apply_reset();
    for (int k = 0; k < NC; k++) raw[k] = (k >= 2 && k <= 4) || (k >= 26);
    build_model(4'b0001);
    run_scan(4'b0001);
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("FAIL hold_last_cycle_trace c=%0d: got %b expected %b", c, act_vec[c], exp_vec[c]);
      end
    end
    checks++;
    if (act_vec[33][4] !== 1'b0 || act_vec[34] !== mk(1, 1, 0, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL hold_last_cycle_lock34: got c33=%b c34=%b expected c34=%b",
               act_vec[33], act_vec[34], mk(1, 1, 0, 1, 0, 0, 0));
    end
  endtask

  task automatic test_loss_of_lock();
    logic any_lol;
    apply_reset();
    lane_ok = 4'b1111;
    for (int k = 0; k < NC; k++) raw[k] = !((k >= 12 && k <= 14) || (k >= 16 && k <= 19));
    build_model(4'b0100);
    run_scan(4'b0100);
    for (int c = 1; c < NC; c++) begin
      checks++;
      if (act_vec[c] !== exp_vec[c]) begin
        fails++;
        $display("FAIL lol_trace c=%0d: got %b expected %b", c, act_vec[c], exp_vec[c]);
      end
    end
    any_lol = 1'b0;
    for (int c = 10; c < 20; c++) any_lol = any_lol | act_vec[c][2];
    checks++;
    if (any_lol !== 1'b0) begin
      fails++;
      $display("FAIL lol_early: got lol in cycles 10..19 = %b expected 0", any_lol);
    end
    checks++;
    if (act_vec[20] !== mk(1, 0, 1, 0, 0, 1, 2)) begin
      fails++;
      $display("FAIL lol_pulse_c20: got %b expected %b", act_vec[20], mk(1, 0, 1, 0, 0, 1, 2));
    end
    checks++;
    if (act_vec[28][4] !== 1'b0 || act_vec[29] !== mk(1, 1, 0, 1, 0, 0, 2)) begin
      fails++;
      $display("FAIL lol_reacquire_c29: got c28=%b c29=%b expected c29=%b",
               act_vec[28], act_vec[29], mk(1, 1, 0, 1, 0, 0, 2));
    end
  endtask

  task automatic test_random();
    logic       b;
    logic [3:0] mask;
    for (int it = 0; it < 8; it++) begin
      apply_reset();
      mask    = (it == 0) ? 4'b0000 : 4'($urandom);
      lane_ok = 4'($urandom);
      b = 1'($urandom % 2);
      for (int k = 0; k < NC; k++) begin
        if ($urandom % 8 == 0) b = ~b;
        raw[k] = b;
      end
      build_model(mask);
      run_scan(mask);
      for (int c = 1; c < NC; c++) begin
        checks++;
        if (act_vec[c] !== exp_vec[c]) begin
          fails++;
          $display("FAIL random_trace it=%0d mask=%b ok=%b c=%0d: got %b expected %b",
                   it, mask, lane_ok, c, act_vec[c], exp_vec[c]);
        end
      end
    end
  endtask

  task automatic test_empty_mask();
    apply_reset();
    lane_mask = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (snap() !== mk(0, 0, 0, 0, 1, 0, 0)) begin
      fails++;
      $display("FAIL empty_mask_fail: got %b expected %b", snap(), mk(0, 0, 0, 0, 1, 0, 0));
    end
    tick();
    checks++;
    if (snap() !== 8'h00) begin
      fails++;
      $display("FAIL empty_mask_one_cycle: got %b expected %b", snap(), 8'h00);
    end
  endtask

  task automatic test_abort();
    logic [5:0] flags;
    logic       seen;
    apply_reset();
    lane_mask = 4'b1111; det_lock = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    flags = {busy, det_en, det_clr, locked, fail, lol};
    checks++;
    if (flags !== 6'b110000) begin
      fails++;
      $display("FAIL abort_pre_acq: got %b expected %b", flags, 6'b110000);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    flags = {busy, det_en, det_clr, locked, fail, lol};
    checks++;
    if (flags !== 6'b000000) begin
      fails++;
      $display("FAIL abort_acq: got %b expected %b", flags, 6'b000000);
    end
    seen = 1'b0;
    repeat (200) begin
      tick();
      seen = seen | fail | lol | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_acq_quiet: got activity=%b expected 0", seen);
    end

    lane_mask = 4'b0001; det_lock = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    flags = {busy, det_en, det_clr, locked, fail, lol};
    checks++;
    if (flags !== 6'b110100) begin
      fails++;
      $display("FAIL abort_pre_locked: got %b expected %b", flags, 6'b110100);
    end
    abort = 1'b1; det_lock = 1'b0;
    tick();
    abort = 1'b0;
    flags = {busy, det_en, det_clr, locked, fail, lol};
    checks++;
    if (flags !== 6'b000000) begin
      fails++;
      $display("FAIL abort_locked: got %b expected %b", flags, 6'b000000);
    end
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | fail | lol | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_locked_quiet: got activity=%b expected 0", seen);
    end

    abort = 1'b1; start = 1'b1; lane_mask = 4'b0000;
    tick();
    abort = 1'b0; start = 1'b0;
    flags = {busy, det_en, det_clr, locked, fail, lol};
    checks++;
    if (flags !== 6'b000000) begin
      fails++;
      $display("FAIL abort_over_start: got %b expected %b", flags, 6'b000000);
    end
  endtask

  task automatic test_reset_mid_confirm();
    apply_reset();
    lane_mask = 4'b0100; det_lock = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (snap() !== mk(1, 1, 0, 0, 0, 0, 2)) begin
      fails++;
      $display("FAIL reset_pre_confirm: got %b expected %b", snap(), mk(1, 1, 0, 0, 0, 0, 2));
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (snap() !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid_confirm: got %b expected %b", snap(), 8'h00);
    end
    rst_n = 1'b1; det_lock = 1'b0;
    tick();
    checks++;
    if (snap() !== 8'h00) begin
      fails++;
      $display("FAIL reset_release_idle: got %b expected %b", snap(), 8'h00);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; det_lock = 1'b0; lane_mask = '0;
    lane_ok = 4'b1111;
    tick();
    test_reset();
    test_single_lock();
    test_full_scan_fail();
    test_skip_lane();
    test_hold_restart();
    test_loss_of_lock();
    test_empty_mask();
    test_abort();
    test_reset_mid_confirm();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bit_lock_scan_ctrl.md
# bit_lock_scan_ctrl

- Scan controller that shares one bit-stream lock detector among `N_LANES` serial input lanes.
- Selects a lane, clears and enables the detector, and waits up to `TIMEOUT` cycles for a lock that persists for `HOLD` samples.
- On timeout it moves to the next enabled lane. Once locked, it monitors for loss of lock and re-acquires.
- Sits between the lane mux / detector datapath and link bring-up software.

## Interface

**Parameters**
- `N_LANES`, default 4: number of lanes scanned; must be ≥2.
- `TIMEOUT`, default 32: acquisition window per lane in cycles, covering ACQ and CONFIRM together; must be > `HOLD`.
- `HOLD`, default 8: consecutive high `det_lock` samples required to declare lock.
- `LOL_FILT`, default 4: consecutive low `det_lock` samples in LOCKED that declare loss of lock.

**Ports**
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin scan; sampled only in IDLE.
- `abort` in 1: return to IDLE from any state; has priority over `start`.
- `lane_mask` in `N_LANES`: lanes allowed to be scanned; captured at `start`.
- `det_lock` in 1: lock indication from the shared detector.
- `det_en` out 1: detector enable.
- `det_clr` out 1: one-cycle synchronous detector clear.
- `lane_sel` out `$clog2(N_LANES)`: mux select to the detector.
- `busy` out 1: state ≠ IDLE.
- `locked` out 1: confirmed lock on `lane_sel`.
- `fail` out 1: one-cycle pulse; no lane locked, or empty mask.
- `lol` out 1: one-cycle pulse on loss of lock.

## Operation

**Reset.** All outputs are registered and reset to 0; `lane_sel`=0; state=IDLE.

**Internal registers.** `mask_q`, window timer `tmr`, `hold_cnt`, `lol_cnt`, and `tried` (count of lanes attempted this scan).

**State machine**
- **IDLE.** `det_en`=0.
  - `start` with `lane_mask`≠0: capture `mask_q`, set `lane_sel` to the lowest set bit, `tried`=1, go to CLEAR.
  - `start` with `lane_mask`=0: `fail` pulses the next cycle; stay in IDLE.
- **CLEAR** (exactly 1 cycle). `det_clr`=1, `det_en`=0; `tmr`, `hold_cnt` and `lol_cnt` cleared. Go to ACQ.
- **ACQ.** `det_en`=1, `tmr`++ every cycle.
  - `det_lock`=1: `hold_cnt`=1, go to CONFIRM.
  - Otherwise, when `tmr` reaches `TIMEOUT`: go to NEXT.
- **CONFIRM.** `det_en`=1, `tmr` keeps counting.
  - `det_lock`=1: `hold_cnt`++. When `hold_cnt` reaches `HOLD`, go to LOCKED. This wins even on the last window cycle.
  - `det_lock`=0: `hold_cnt`=0, back to ACQ; the timer is not restarted.
  - Window expiry without `HOLD` samples: go to NEXT.
- **LOCKED.** `det_en`=1, `locked`=1.
  - `det_lock`=0 increments `lol_cnt`; `det_lock`=1 clears it.
  - When `lol_cnt` reaches `LOL_FILT`: `locked` drops, `lol` pulses, `tried`=1, go to CLEAR on the same lane.
- **NEXT** (1 cycle). `det_en`=0.
  - If `tried` equals popcount(`mask_q`): go to IDLE; `fail` pulses on the first IDLE cycle.
  - Otherwise: set `lane_sel` to the next set bit of `mask_q` above the current lane, wrapping circularly; `tried`++; go to CLEAR.

**Other rules**
- `abort`: next state is IDLE; `det_en`, `locked` and `busy` are 0 on the next cycle. No `fail` or `lol` pulse.
- `start` outside IDLE is ignored. `lane_mask` changes after capture are ignored.
- A single-lane mask that times out produces a `fail` pulse; it is not retried.
- `tmr` has width `$clog2(TIMEOUT+1)` and never wraps.

## Timing

- Latency counts from `start` sampled at cycle 0:
  - CLEAR at cycle 1.
  - First `det_en` at cycle 2.
- With `det_lock` held high from cycle 2: samples at cycles 2..2+`HOLD`-1, `locked`=1 at cycle 2+`HOLD` (10 with defaults).
- Failing lane index k (0-based scan order):
  - CLEAR at 1+k(`TIMEOUT`+2).
  - ACQ window of exactly `TIMEOUT` cycles.
  - NEXT at 2+`TIMEOUT`+k(`TIMEOUT`+2).
- Full-scan failure, `fail` high at cycle 3+`TIMEOUT`+(m-1)(`TIMEOUT`+2), where m = popcount(mask). With defaults and 4 lanes this is cycle 137.
- Loss of lock: `lol` and `locked`=0 appear in the cycle after the `LOL_FILT`-th low sample; that cycle is CLEAR with `det_clr`=1.
- `lane_sel` changes only on entry to CLEAR and is stable while `det_en`=1.

## Test plan

- Mask 4'b0010, `start`, `det_lock` high from cycle 2 → `lane_sel`=1, `det_clr` at cycle 1, `locked`=1 at cycle 10, `busy`=1.
- Mask 4'b1111, `det_lock` always 0 → lanes visited 0,1,2,3; `fail` one-cycle pulse at cycle 137; `busy`=0 afterwards.
- Mask 4'b1010, `det_lock` high only while `lane_sel`=3 → lane 1 times out, lock on lane 3 at cycle 2+34+8=44.
- `det_lock` pattern 1,1,1,0 then steady 1 in ACQ → `hold_cnt` restarts; lock confirmed 8 samples after the re-rise, inside the window. Same pattern arranged so the 8th sample lands at `tmr`=`TIMEOUT` → LOCKED, not NEXT.
- Locked, then `det_lock` low 3 cycles, high 1, low 4 → no `lol` after the 3 lows; `lol` pulse plus CLEAR after the 4th consecutive low; reacquires on the same `lane_sel`.
- `abort` during ACQ and during LOCKED → IDLE next cycle, all outputs 0, no `fail` or `lol`. `start` with mask 0 → `fail` pulse only. `rst_n`=0 mid-CONFIRM → all outputs 0 on the next edge.
